// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forward-select codes, FSM states, shadow slots.
// Pure declarations; no timing or flow-control behaviour lives here.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       muldiv;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // x0 is hard-wired, so a write to it never produces a value worth forwarding.
    function automatic logic slot_match(input logic       valid,
                                        input logic       reg_write,
                                        input logic [4:0] rd,
                                        input logic       use_rs,
                                        input logic [4:0] rs);
        return use_rs && valid && reg_write && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard inputs and EX/pipeline control outputs of the hazard controller.
// master = pipeline side driving ID info, slave = hazard_ctrl.
interface hazard_ctrl_if;

    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_muldiv;
    logic       ex_flush_req;
    logic       md_done;

    logic [1:0] forwardA;
    logic [1:0] forwardB;
    logic       stall_if_id;
    logic       bubble_ex;
    logic       flush_if_id;
    logic       hold_ex;
    logic       bubble_mem;
    logic       md_start;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_mem_read, id_muldiv, ex_flush_req, md_done,
        input  forwardA, forwardB, stall_if_id, bubble_ex, flush_if_id,
               hold_ex, bubble_mem, md_start
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_mem_read, id_muldiv, ex_flush_req, md_done,
        output forwardA, forwardB, stall_if_id, bubble_ex, flush_if_id,
               hold_ex, bubble_mem, md_start
    );

endinterface

// File: rtl/fwd_sel.sv
// Forward-source priority for one EX operand against the EX and MEM shadow slots.
// Purely combinational; no backpressure.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic       use_i,
    input  logic [4:0] rs_i,
    input  logic       ex_valid_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_reg_write_i,
    input  logic       ex_mem_read_i,
    input  logic       mem_valid_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_reg_write_i,
    output logic [1:0] sel_o,
    output logic       ex_load_hit_o
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit        = slot_match(ex_valid_i, ex_reg_write_i, ex_rd_i, use_i, rs_i);
    assign mem_hit       = slot_match(mem_valid_i, mem_reg_write_i, mem_rd_i, use_i, rs_i);
    assign ex_load_hit_o = ex_hit && ex_mem_read_i;

    // A load still in EX has no data yet; an older MEM producer may still cover it.
    always_comb begin
        sel_o = FWD_REG;
        if (ex_hit && !ex_mem_read_i) begin
            sel_o = FWD_MEM;
        end else if (mem_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: registered EX forward selects, load-use stall, flush, optional mul/div hold (HAZARD_MULDIV_EN).
// Selects valid in the instruction's first EX cycle; stall/bubble/flush/hold are combinational, hold lasts until md_done.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    hz_state_e  state_q, state_d;
    slot_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic       md_start_q, md_start_d;

    logic [1:0] sel_a, sel_b;
    logic       hit_a, hit_b;
    logic       load_use;
    logic       md_busy;
    logic       stall, bubble, flush;
    logic       md_done_w, id_muldiv_w;

`ifdef HAZARD_MULDIV_EN
    assign md_done_w   = hz.md_done;
    assign id_muldiv_w = hz.id_muldiv;
`else
    assign md_done_w   = 1'b0;
    assign id_muldiv_w = 1'b0;
`endif

    fwd_sel u_fwd_a (
        .use_i           (hz.id_use_rs1),
        .rs_i            (hz.id_rs1),
        .ex_valid_i      (ex_q.valid),
        .ex_rd_i         (ex_q.rd),
        .ex_reg_write_i  (ex_q.reg_write),
        .ex_mem_read_i   (ex_q.mem_read),
        .mem_valid_i     (mem_q.valid),
        .mem_rd_i        (mem_q.rd),
        .mem_reg_write_i (mem_q.reg_write),
        .sel_o           (sel_a),
        .ex_load_hit_o   (hit_a)
    );

    fwd_sel u_fwd_b (
        .use_i           (hz.id_use_rs2),
        .rs_i            (hz.id_rs2),
        .ex_valid_i      (ex_q.valid),
        .ex_rd_i         (ex_q.rd),
        .ex_reg_write_i  (ex_q.reg_write),
        .ex_mem_read_i   (ex_q.mem_read),
        .mem_valid_i     (mem_q.valid),
        .mem_rd_i        (mem_q.rd),
        .mem_reg_write_i (mem_q.reg_write),
        .sel_o           (sel_b),
        .ex_load_hit_o   (hit_b)
    );

    assign load_use = hz.id_valid && (hit_a || hit_b);
    // The cycle md_done arrives behaves as a normal advance, so done-with-start costs one cycle.
    assign md_busy  = (state_q == ST_MD_WAIT) && !md_done_w;

    always_comb begin
        state_d    = state_q;
        ex_d       = ex_q;
        mem_d      = mem_q;
        wb_d       = wb_q;
        fwd_a_d    = fwd_a_q;
        fwd_b_d    = fwd_b_q;
        md_start_d = 1'b0;
        stall      = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;

        case (state_q)
            ST_MD_WAIT: begin
                if (md_busy) begin
                    stall = 1'b1;
                    wb_d  = mem_q;
                    mem_d = SLOT_EMPTY;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (!md_busy) begin
            flush  = hz.ex_flush_req;
            stall  = load_use && !flush;
            bubble = flush || load_use;
            wb_d   = mem_q;
            mem_d  = ex_q;
            if (bubble || !hz.id_valid) begin
                ex_d    = SLOT_EMPTY;
                fwd_a_d = FWD_REG;
                fwd_b_d = FWD_REG;
            end else begin
                ex_d    = '{valid: 1'b1, rd: hz.id_rd, reg_write: hz.id_reg_write,
                            mem_read: hz.id_mem_read, muldiv: id_muldiv_w};
                fwd_a_d = sel_a;
                fwd_b_d = sel_b;
            end
            md_start_d = ex_d.valid && ex_d.muldiv;
            if (md_start_d) begin
                state_d = ST_MD_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            ex_q       <= SLOT_EMPTY;
            mem_q      <= SLOT_EMPTY;
            wb_q       <= SLOT_EMPTY;
            fwd_a_q    <= FWD_REG;
            fwd_b_q    <= FWD_REG;
            md_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ex_q       <= ex_d;
            mem_q      <= mem_d;
            wb_q       <= wb_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
            md_start_q <= md_start_d;
        end
    end

    assign hz.forwardA    = fwd_a_q;
    assign hz.forwardB    = fwd_b_q;
    assign hz.stall_if_id = stall;
    assign hz.bubble_ex   = bubble;
    assign hz.flush_if_id = flush;

`ifdef HAZARD_MULDIV_EN
    assign hz.hold_ex    = md_busy;
    assign hz.bubble_mem = md_busy;
    assign hz.md_start   = md_start_q;
    // WB needs no forwarding (write-first regfile); the slot is kept for pipeline visibility only.
    logic unused_ok;
    assign unused_ok = &{1'b0, wb_q, mem_q.mem_read, mem_q.muldiv, ex_q.muldiv};
`else
    assign hz.hold_ex    = 1'b0;
    assign hz.bubble_mem = 1'b0;
    assign hz.md_start   = 1'b0;
    logic unused_ok;
    assign unused_ok = &{1'b0, wb_q, mem_q.mem_read, mem_q.muldiv, ex_q.muldiv,
                         md_start_q, hz.md_done, hz.id_muldiv};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against an instruction-queue model of the pipeline.
// Builds with or without HAZARD_MULDIV_EN.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    hazard_ctrl_if hz();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
        bit       md;
    } ins_t;

    // Instructions in flight, youngest first: [0] in EX, [1] in MEM, [2] in WB.
    ins_t pipe[$];
    ins_t nop;
    bit   md_wait;
    int   exp_fa, exp_fb;
    bit   exp_start;
    bit   busy, e_stall, e_bex, e_flush;
    bit   keep_id;
    int   n_chk, n_pass;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic bit writes(input ins_t i, input bit u, input bit [4:0] rs);
        return u && i.v && i.wr && (i.rd != 5'd0) && (i.rd == rs);
    endfunction

    // Result one stage ahead comes off the MEM ALU path, two stages ahead off WB.
    function automatic int fsel(input bit u, input bit [4:0] rs);
        if (writes(pipe[0], u, rs) && !pipe[0].ld) return 2;
        if (writes(pipe[1], u, rs)) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        pipe.delete();
        repeat (3) pipe.push_back(nop);
        md_wait   = 1'b0;
        exp_fa    = 0;
        exp_fb    = 0;
        exp_start = 1'b0;
        keep_id   = 1'b0;
    endtask

    task automatic predict();
        bit lu;
        busy = MD_EN && md_wait && !hz.md_done;
        if (busy) begin
            e_stall = 1'b1;
            e_bex   = 1'b0;
            e_flush = 1'b0;
        end else begin
            lu = hz.id_valid && pipe[0].ld &&
                 (writes(pipe[0], hz.id_use_rs1, hz.id_rs1) ||
                  writes(pipe[0], hz.id_use_rs2, hz.id_rs2));
            e_flush = hz.ex_flush_req;
            e_stall = lu && !e_flush;
            e_bex   = e_flush || lu;
        end
    endtask

    task automatic advance();
        ins_t n;
        n = nop;
        if (busy) begin
            pipe[2]   = pipe[1];
            pipe[1]   = nop;
            exp_start = 1'b0;
        end else begin
            if (hz.id_valid && !e_bex) begin
                n.v  = 1'b1;
                n.rd = hz.id_rd;
                n.wr = hz.id_reg_write;
                n.ld = hz.id_mem_read;
                n.md = MD_EN && hz.id_muldiv;
            end
            exp_fa = n.v ? fsel(hz.id_use_rs1, hz.id_rs1) : 0;
            exp_fb = n.v ? fsel(hz.id_use_rs2, hz.id_rs2) : 0;
            pipe.push_front(n);
            void'(pipe.pop_back());
            md_wait   = n.v && n.md;
            exp_start = md_wait;
        end
    endtask

    task automatic check_all();
        check("forwardA",    int'(hz.forwardA),    exp_fa);
        check("forwardB",    int'(hz.forwardB),    exp_fb);
        check("stall_if_id", int'(hz.stall_if_id), int'(e_stall));
        check("bubble_ex",   int'(hz.bubble_ex),   int'(e_bex));
        check("flush_if_id", int'(hz.flush_if_id), int'(e_flush));
        check("hold_ex",     int'(hz.hold_ex),     int'(busy));
        check("bubble_mem",  int'(hz.bubble_mem),  int'(busy));
        check("md_start",    int'(hz.md_start),    int'(exp_start));
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_forwardA"},    int'(hz.forwardA),    0);
        check({pfx, "_forwardB"},    int'(hz.forwardB),    0);
        check({pfx, "_stall_if_id"}, int'(hz.stall_if_id), 0);
        check({pfx, "_bubble_ex"},   int'(hz.bubble_ex),   0);
        check({pfx, "_flush_if_id"}, int'(hz.flush_if_id), 0);
        check({pfx, "_hold_ex"},     int'(hz.hold_ex),     0);
        check({pfx, "_bubble_mem"},  int'(hz.bubble_mem),  0);
        check({pfx, "_md_start"},    int'(hz.md_start),    0);
    endtask

    // Small register range so producers and consumers collide often, including x0.
    task automatic drive(input bit keep);
        if (!keep) begin
            hz.id_valid     = ($urandom_range(0, 9) != 0);
            hz.id_rs1       = 5'($urandom_range(0, 3));
            hz.id_rs2       = 5'($urandom_range(0, 3));
            hz.id_use_rs1   = 1'($urandom_range(0, 3) != 0);
            hz.id_use_rs2   = 1'($urandom_range(0, 1));
            hz.id_rd        = 5'($urandom_range(0, 3));
            hz.id_reg_write = 1'($urandom_range(0, 4) != 0);
            hz.id_mem_read  = ($urandom_range(0, 3) == 0);
            hz.id_muldiv    = ($urandom_range(0, 6) == 0);
        end
        hz.ex_flush_req = ($urandom_range(0, 9) == 0);
        hz.md_done      = ($urandom_range(0, 2) == 0);
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            drive(keep_id);
            #1;
            predict();
            check_all();
            @(posedge clk);
            advance();
            keep_id = e_stall;
        end
    endtask

    task automatic set_idle();
        hz.id_valid     = 1'b0;
        hz.id_rs1       = 5'd0;
        hz.id_rs2       = 5'd0;
        hz.id_use_rs1   = 1'b0;
        hz.id_use_rs2   = 1'b0;
        hz.id_rd        = 5'd0;
        hz.id_reg_write = 1'b0;
        hz.id_mem_read  = 1'b0;
        hz.id_muldiv    = 1'b0;
        hz.ex_flush_req = 1'b0;
        hz.md_done      = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        set_idle();
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_cycles(600);

        // Park a mul/div in EX, then pull reset while it waits.
        @(negedge clk);
        set_idle();
        hz.id_valid     = 1'b1;
        hz.id_rd        = 5'd3;
        hz.id_reg_write = 1'b1;
        hz.id_muldiv    = 1'b1;
        #1;
        predict();
        check_all();
        @(posedge clk);
        advance();
        @(negedge clk);
        set_idle();
        #1;
        predict();
        check_all();
        check("md_wait_hold", int'(hz.hold_ex), int'(MD_EN));
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_cycles(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It keeps a shadow record of destination registers in EX/MEM/WB and produces registered forwarding selects for the EX-stage ALU operand muxes. It also detects load-use hazards, sequences the stall/bubble/flush controls for IF/ID and ID/EX, and optionally holds EX for a multi-cycle mul/div unit. It sits beside the ID/EX pipeline register; its selects drive the EX operand-source mux directly.

## Interface
Parameters:
- none (widths fixed by RV32: 5-bit register index).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5  source register indices in ID.
- id_use_rs1, id_use_rs2  in  1  instruction reads that source.
- id_rd  in  5  destination index in ID.
- id_reg_write  in  1  instruction writes rd.
- id_mem_read  in  1  instruction is a load.
- id_muldiv  in  1  instruction is mul/div (only with HAZARD_MULDIV_EN).
- ex_flush_req  in  1  taken branch/jump resolved in EX.
- md_done  in  1  mul/div result valid (only with HAZARD_MULDIV_EN).
- forwardA, forwardB  out  2  EX operand select: 0 regfile, 1 WB data (dataD), 2 MEM ALU result; 3 never driven.
- stall_if_id  out  1  hold PC and IF/ID.
- bubble_ex  out  1  ID/EX loads a NOP.
- flush_if_id  out  1  IF/ID loads a NOP.
- hold_ex  out  1  ID/EX holds (mul/div only, else 0).
- bubble_mem  out  1  EX/MEM loads a NOP (mul/div only, else 0).
- md_start  out  1  one-cycle pulse; mul/div captures operands.

## Operation
- Shadow slots EX, MEM, WB. Each slot holds {valid, rd, reg_write, mem_read, muldiv}. On an advance edge: WB<=MEM, MEM<=EX, EX<=ID entry. A bubble or flush loads EX with valid=0.
- Match rule: a source matches a slot when use=1, slot valid, reg_write=1, rd!=0, and rd==rs.
- Next forward select for each operand, computed in ID:
  - Match in EX slot with mem_read=0 -> 2.
  - Otherwise, match in MEM slot -> 1.
  - Otherwise -> 0.
  - The EX slot has priority because it holds the newer producer.
- Regfile is write-first. A WB-slot producer therefore needs no forwarding.
- Load-use: if the EX slot is a load and either used source of a valid ID instruction matches it, assert stall_if_id=1 and bubble_ex=1 for exactly one cycle. The consumer then sees the load in MEM and gets select 1.
- ex_flush_req=1: assert flush_if_id=1 and bubble_ex=1. The EX slot receives the bubble. Flush overrides load-use stall in the same cycle.
- FSM states:
  - RUN: normal operation.
  - MD_WAIT: mul/div in EX.
  - RUN->MD_WAIT when the EX slot becomes a muldiv.
  - MD_WAIT->RUN on md_done.
- In MD_WAIT: stall_if_id=1, hold_ex=1, bubble_mem=1. Shadow EX and forward selects are held; MEM gets bubbles and WB drains. ex_flush_req is ignored.
- md_start pulses in the first cycle the muldiv sits in EX. The unit latches its operands then, so later WB-forward changes are harmless.
- md_done arriving in the same cycle as md_start finishes in one cycle.

## Timing
- forwardA/forwardB are registered. They update on every edge where ID/EX loads (not hold_ex) and are valid throughout the instruction's first EX cycle. A bubble entering EX gets selects 0.
- stall_if_id, bubble_ex, flush_if_id, hold_ex, bubble_mem are combinational from the current slots, ID inputs and state.
- Load-use penalty: 1 cycle. Mul/div penalty: cycles until md_done.
- Reset values:
  - All slots invalid, state RUN.
  - forwardA=forwardB=0.
  - All control outputs 0, md_start=0.
- Reset asserted mid-stall or in MD_WAIT aborts immediately to these values.

## Configuration
- HAZARD_MULDIV_EN defined: id_muldiv, md_done, hold_ex, bubble_mem and md_start are active, and the FSM includes MD_WAIT.
- Not defined: the ports remain, inputs are ignored, outputs are tied to 0, and the FSM has only RUN.

## Structure
- hazard_pkg:
  - Select constants FWD_REG=2'd0, FWD_WB=2'd1, FWD_MEM=2'd2.
  - FSM state enum.
  - Shadow-slot struct type.
- Sub-module fwd_sel: combinational match/priority for one operand, instantiated twice (rs1 to forwardA, rs2 to forwardB).

## Test plan
- `add x5` followed by `sub x6,x5,x1` -> sub in EX has forwardA=2, no stall.
- `add x5`, unrelated instruction, then `or x7,x1,x5` -> forwardB=1.
- `lw x5` followed by `add x6,x5,x5` -> stall_if_id=bubble_ex=1 for 1 cycle, then add in EX with forwardA=forwardB=1.
- `addi x0,x0,1` followed by a read of x0 -> selects 0. Simultaneous load-use and ex_flush_req -> flush_if_id=1, no stall.
- With HAZARD_MULDIV_EN: `mul x3` with md_done after 4 cycles -> md_start pulses once, hold_ex=1 for 4 cycles, dependent instruction then gets forwardA=2.
- Assert rst_n=0 during MD_WAIT -> all outputs 0 asynchronously, state RUN after release.
